// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: byte-framed command sequencer between the UART RX path and the
// register file / ALU / UART TX FIFO.
// Commands: 0xAA write (ADDR, DATA), 0xBB read (ADDR),
//           0xCC ALU with operands (A, B, FUN), 0xDD ALU without operands (FUN).
// Optional feature: define CMD_TIMEOUT_EN to abandon a partial command after
// TIMEOUT_CYCLES cycles without a received byte.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_RD    = 4'd9,
    ST_TX_LO    = 4'd10,
    ST_TX_HI    = 4'd11
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  state_t                  state, state_nx;
  logic [2*DATA_WIDTH-1:0] res, res_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   wrdata_nx, txdata_nx;
  logic [FUN_WIDTH-1:0]    alufun_nx;
  logic                    wren_nx, rden_nx, aluen_nx, clken_nx, txvld_nx;
  logic                    tmo_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting;

  assign waiting = (state == ST_WR_ADDR) || (state == ST_WR_DATA) ||
                   (state == ST_RD_ADDR) || (state == ST_OP_A)    ||
                   (state == ST_OP_B)    || (state == ST_ALU_FUN);
  assign tmo_hit = waiting && !RX_D_VLD &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte silence counter, cleared by every received byte and outside byte-waiting states
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= {TMO_W{1'b0}};
    end else if (RX_D_VLD || !waiting) begin
      tmo_cnt <= {TMO_W{1'b0}};
    end else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State and registered outputs; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      res       <= {(2*DATA_WIDTH){1'b0}};
      Address   <= {ADDR_WIDTH{1'b0}};
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WrData    <= {DATA_WIDTH{1'b0}};
      ALU_EN    <= 1'b0;
      ALU_FUN   <= {FUN_WIDTH{1'b0}};
      CLK_EN    <= 1'b0;
      TX_P_DATA <= {DATA_WIDTH{1'b0}};
      TX_D_VLD  <= 1'b0;
    end else begin
      state     <= state_nx;
      res       <= res_nx;
      Address   <= addr_nx;
      WrEn      <= wren_nx;
      RdEn      <= rden_nx;
      WrData    <= wrdata_nx;
      ALU_EN    <= aluen_nx;
      ALU_FUN   <= alufun_nx;
      CLK_EN    <= clken_nx;
      TX_P_DATA <= txdata_nx;
      TX_D_VLD  <= txvld_nx;
    end
  end

  // Next-state decode and next values of the output registers
  always_comb begin
    state_nx  = state;
    res_nx    = res;
    addr_nx   = Address;
    wrdata_nx = WrData;
    alufun_nx = ALU_FUN;
    txdata_nx = TX_P_DATA;
    wren_nx   = 1'b0;
    rden_nx   = 1'b0;
    aluen_nx  = 1'b0;
    txvld_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state_nx = ST_WR_ADDR;
            CMD_RD:     state_nx = ST_RD_ADDR;
            CMD_ALU_OP: state_nx = ST_OP_A;
            CMD_ALU_NO: state_nx = ST_ALU_FUN;
            default:    state_nx = ST_IDLE;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx = ST_WR_DATA;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wren_nx   = 1'b1;
          wrdata_nx = RX_P_DATA;
          state_nx  = ST_IDLE;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rden_nx  = 1'b1;
          addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx = ST_RD_WAIT;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      ST_RD_WAIT: begin
        // A valid coinciding with our own RdEn strobe belongs to no request of ours
        if (RdData_Valid && !RdEn) begin
          res_nx   = {{DATA_WIDTH{1'b0}}, RdData};
          state_nx = ST_TX_RD;
        end else begin
          state_nx = state;
        end
      end
      ST_OP_A, ST_OP_B: begin
        if (RX_D_VLD) begin
          wren_nx   = 1'b1;
          wrdata_nx = RX_P_DATA;
          addr_nx   = (state == ST_OP_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          state_nx  = (state == ST_OP_A) ? ST_OP_B : ST_ALU_FUN;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          aluen_nx  = 1'b1;
          alufun_nx = RX_P_DATA[FUN_WIDTH-1:0];
          state_nx  = ST_ALU_WAIT;
        end else if (tmo_hit) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      ST_ALU_WAIT: begin
        if (OUT_Valid && !ALU_EN) begin
          res_nx   = ALU_OUT;
          state_nx = ST_TX_LO;
        end else begin
          state_nx = state;
        end
      end
      ST_TX_RD, ST_TX_LO, ST_TX_HI: begin
        if (!FIFO_FULL) begin
          txvld_nx  = 1'b1;
          txdata_nx = (state == ST_TX_HI) ? res[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : res[DATA_WIDTH-1:0];
          state_nx  = (state == ST_TX_LO) ? ST_TX_HI : ST_IDLE;
        end else begin
          state_nx = state;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // ALU clock runs from entering the function-byte wait until the result is captured
    clken_nx = (state_nx == ST_ALU_FUN) || (state_nx == ST_ALU_WAIT);
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl. Honors CMD_TIMEOUT_EN when defined.
module tb_sys_cmd_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int TMO = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   RX_P_DATA = '0;
  logic            RX_D_VLD = 1'b0;
  logic [AW-1:0]   Address;
  logic            WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [DW-1:0]   WrData, TX_P_DATA;
  logic [DW-1:0]   RdData = '0;
  logic            RdData_Valid = 1'b0;
  logic [FW-1:0]   ALU_FUN;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic            OUT_Valid = 1'b0;
  logic            FIFO_FULL = 1'b0;

  sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Strobe monitor: counts pulses and logs transmitted bytes
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0;
  logic [DW-1:0] tx_log [0:63];
  always @(negedge clk) begin
    if (WrEn) wr_cnt++;
    if (RdEn) rd_cnt++;
    if (ALU_EN) alu_cnt++;
    if (TX_D_VLD) begin
      tx_log[tx_cnt[5:0]] = TX_P_DATA;
      tx_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was sampled
  task automatic send(input logic [DW-1:0] b);
    @(negedge clk);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge clk);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int wr0, rd0, alu0, tx0;

  initial begin
    // Reset state
    idle(3);
    check("rst_wren", {31'd0, WrEn}, 32'd0);
    check("rst_rden", {31'd0, RdEn}, 32'd0);
    check("rst_aluen", {31'd0, ALU_EN}, 32'd0);
    check("rst_clken", {31'd0, CLK_EN}, 32'd0);
    check("rst_txvld", {31'd0, TX_D_VLD}, 32'd0);
    check("rst_addr", {28'd0, Address}, 32'd0);
    check("rst_wrdata", {24'd0, WrData}, 32'd0);
    check("rst_alufun", {28'd0, ALU_FUN}, 32'd0);
    check("rst_txdata", {24'd0, TX_P_DATA}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Write: AA 05 3C
    wr0 = wr_cnt;
    send(8'hAA); send(8'h05);
    check("wr_no_early", {31'd0, WrEn}, 32'd0);
    send(8'h3C);
    check("wr_en", {31'd0, WrEn}, 32'd1);
    check("wr_addr", {28'd0, Address}, 32'd5);
    check("wr_data", {24'd0, WrData}, 32'h3C);
    idle(1);
    check("wr_pulse_end", {31'd0, WrEn}, 32'd0);
    idle(2);
    check("wr_count", wr_cnt - wr0, 32'd1);

    // Read: BB 05, bogus valid in RdEn cycle, dropped byte, data 3 cycles later
    rd0 = rd_cnt; tx0 = tx_cnt; wr0 = wr_cnt;
    send(8'hBB); send(8'h05);
    check("rd_en", {31'd0, RdEn}, 32'd1);
    check("rd_addr", {28'd0, Address}, 32'd5);
    RdData = 8'h99; RdData_Valid = 1'b1;
    @(negedge clk);
    RdData_Valid = 1'b0;
    send(8'hAA);
    @(negedge clk);
    RdData = 8'h3C; RdData_Valid = 1'b1;
    @(negedge clk);
    RdData_Valid = 1'b0;
    idle(4);
    check("rd_count", rd_cnt - rd0, 32'd1);
    check("rd_tx_count", tx_cnt - tx0, 32'd1);
    check("rd_tx_byte", {24'd0, tx_log[tx0[5:0]]}, 32'h3C);
    check("rd_drop_no_wr", wr_cnt - wr0, 32'd0);

    // ALU with operands: CC 12 34 00, result 0x0046
    wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
    send(8'hCC); send(8'h12);
    check("opa_wren", {31'd0, WrEn}, 32'd1);
    check("opa_addr", {28'd0, Address}, 32'd0);
    check("opa_data", {24'd0, WrData}, 32'h12);
    check("opa_clken", {31'd0, CLK_EN}, 32'd0);
    send(8'h34);
    check("opb_wren", {31'd0, WrEn}, 32'd1);
    check("opb_addr", {28'd0, Address}, 32'd1);
    check("opb_data", {24'd0, WrData}, 32'h34);
    check("opb_clken", {31'd0, CLK_EN}, 32'd1);
    send(8'h00);
    check("alu_en", {31'd0, ALU_EN}, 32'd1);
    check("alu_fun0", {28'd0, ALU_FUN}, 32'd0);
    ALU_OUT = 16'h0046;
    @(negedge clk);
    check("alu_clken_wait", {31'd0, CLK_EN}, 32'd1);
    OUT_Valid = 1'b1;
    @(negedge clk);
    OUT_Valid = 1'b0;
    check("alu_clken_off", {31'd0, CLK_EN}, 32'd0);
    idle(4);
    check("alu_wr_count", wr_cnt - wr0, 32'd2);
    check("alu_en_count", alu_cnt - alu0, 32'd1);
    check("alu_tx_count", tx_cnt - tx0, 32'd2);
    check("alu_tx_lo", {24'd0, tx_log[tx0[5:0]]}, 32'h46);
    check("alu_tx_hi", {24'd0, tx_log[6'(tx0 + 1)]}, 32'h00);

    // ALU without operands: DD 02, FIFO full for 10 cycles after the result
    tx0 = tx_cnt; wr0 = wr_cnt;
    FIFO_FULL = 1'b1;
    send(8'hDD);
    check("dd_clken", {31'd0, CLK_EN}, 32'd1);
    send(8'h02);
    check("dd_alu_en", {31'd0, ALU_EN}, 32'd1);
    check("dd_alu_fun", {28'd0, ALU_FUN}, 32'd2);
    ALU_OUT = 16'hA55A;
    @(negedge clk);
    OUT_Valid = 1'b1;
    @(negedge clk);
    OUT_Valid = 1'b0;
    idle(10);
    check("full_no_tx", tx_cnt - tx0, 32'd0);
    FIFO_FULL = 1'b0;
    idle(4);
    check("dd_tx_count", tx_cnt - tx0, 32'd2);
    check("dd_tx_lo", {24'd0, tx_log[tx0[5:0]]}, 32'h5A);
    check("dd_tx_hi", {24'd0, tx_log[6'(tx0 + 1)]}, 32'hA5);
    check("dd_no_wr", wr_cnt - wr0, 32'd0);

    // Unknown command byte, then data bytes that must not be taken as a command
    wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt;
    send(8'h55); send(8'h05); send(8'h3C);
    idle(2);
    check("unk_no_wr", wr_cnt - wr0, 32'd0);
    check("unk_no_rd", rd_cnt - rd0, 32'd0);
    check("unk_no_alu", alu_cnt - alu0, 32'd0);
    check("unk_clken", {31'd0, CLK_EN}, 32'd0);

    // Partial write discarded by reset
    wr0 = wr_cnt;
    send(8'hAA);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h07); send(8'h3C);
    idle(2);
    check("rst_mid_no_wr", wr_cnt - wr0, 32'd0);
    check("rst_mid_addr", {28'd0, Address}, 32'd0);

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout abandons the write
    wr0 = wr_cnt;
    send(8'hAA); send(8'h05);
    idle(TMO + 4);
    send(8'h3C);
    idle(2);
    check("tmo_no_wr", wr_cnt - wr0, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
